// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types for the SDRAM ROM-slot arbiter: FSM state encoding and data width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtframe_sdram_arb_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Round-robin priority picker: first requesting slot at or after i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_valid just reports that some request is present.
module jtframe_rr_pick
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int PW    = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic             o_valid,
  output logic [PW-1:0]    o_idx
);

  // w_pos[k] is the slot that sits k places after the pointer, modulo SLOTS
  logic [PW-1:0] w_pos [SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_pos
    assign w_pos[g] = ((int'(i_ptr) + g) >= SLOTS) ? PW'(int'(i_ptr) + g - SLOTS)
                                                   : PW'(int'(i_ptr) + g);
  end

  // Scan from the farthest position back to the pointer so the nearest requester wins
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (i_req[w_pos[k]]) o_idx = w_pos[k];
    end
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing the SDRAM read channel among ROM slots, one transaction in flight.
// Latency: grant 1 cycle after request; slot_ok = ack wait + rdy wait + 1 cycle after grant.
// Backpressure: slots hold i_slot_req until o_slot_ok; no grants while i_downloading is high.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int TOUTW = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_downloading,
  input  logic [SLOTS-1:0]   i_slot_req,
  input  logic [SLOTS*AW-1:0] i_slot_addr,
  input  logic [SLOTS*2-1:0] i_slot_bank,
  output logic [SLOTS-1:0]   o_slot_ok,
  output logic [DW-1:0]      o_slot_dout,
  output logic               o_sdram_req,
  output logic [AW-1:0]      o_sdram_addr,
  output logic [1:0]         o_sdram_bank,
  input  logic               i_sdram_ack,
  input  logic               i_data_rdy,
  input  logic [DW-1:0]      i_data_read,
  output logic               o_busy,
  output logic               o_tout_err
);

  localparam int PW = $clog2(SLOTS);
  // Last watchdog value before all-ones: one more idle WAIT_RDY cycle means timeout
  localparam logic [TOUTW-1:0] TOUT_LAST = TOUTW'((2 ** TOUTW) - 2);

  arb_state_t       r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_gnt;
  logic [TOUTW-1:0] r_wdog;

  logic             w_valid;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_gnt_next;

  jtframe_rr_pick #(
    .SLOTS (SLOTS),
    .PW    (PW)
  ) u_pick (
    .i_req   (i_slot_req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_gnt_next = (r_gnt == PW'(SLOTS - 1)) ? '0 : r_gnt + PW'(1);

  // Data goes to the granted slot only if it is still asking for it during DONE
  always_comb begin
    o_slot_ok = '0;
    if (r_state == DONE) o_slot_ok[r_gnt] = i_slot_req[r_gnt];
  end

  // Transaction FSM: grant, wait for controller ack, wait for data (watchdogged), deliver
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_wdog       <= '0;
      o_slot_dout  <= '0;
      o_sdram_req  <= 1'b0;
      o_sdram_addr <= '0;
      o_sdram_bank <= '0;
      o_busy       <= 1'b0;
      o_tout_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!i_downloading && w_valid) begin
            r_gnt        <= w_idx;
            o_sdram_addr <= i_slot_addr[int'(w_idx)*AW +: AW];
            o_sdram_bank <= i_slot_bank[int'(w_idx)*2 +: 2];
            o_sdram_req  <= 1'b1;
            o_busy       <= 1'b1;
            r_state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (i_sdram_ack) begin
            o_sdram_req <= 1'b0;
            r_wdog      <= '0;
            // Data arriving with the ack counts as ack followed by rdy
            if (i_data_rdy) begin
              o_slot_dout <= i_data_read;
              r_state     <= DONE;
            end else begin
              r_state     <= WAIT_RDY;
            end
          end
        end
        WAIT_RDY: begin
          if (i_data_rdy) begin
            o_slot_dout <= i_data_read;
            r_state     <= DONE;
          end else if (r_wdog == TOUT_LAST) begin
            // Give up on this slot and move on; the error stays flagged until reset
            o_tout_err <= 1'b1;
            r_rr_ptr   <= w_gnt_next;
            o_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_wdog <= r_wdog + TOUTW'(1);
          end
        end
        DONE: begin
          r_rr_ptr <= w_gnt_next;
          o_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: directed table, corner sequences, random traffic.
// Latency: n/a (testbench).
// Backpressure: bench plays both the ROM slots and the SDRAM controller.
module tb_jtframe_sdram_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                dl = 1'b0;
  logic [SLOTS-1:0]    req = '0;
  logic [SLOTS*AW-1:0] addr_v = '0;
  logic [SLOTS*2-1:0]  bank_v = '0;
  logic                ack = 1'b0;
  logic                rdy = 1'b0;
  logic [31:0]         rdata = '0;

  logic [SLOTS-1:0]    ok;
  logic [31:0]         dout;
  logic                sreq;
  logic [AW-1:0]       saddr;
  logic [1:0]          sbank;
  logic                busy;
  logic                tout;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: slot addresses/banks and the round-robin pointer
  logic [AW-1:0] m_addr [SLOTS];
  logic [1:0]    m_bank [SLOTS];
  int            m_ptr = 0;

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .TOUTW(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_downloading (dl),
    .i_slot_req    (req),
    .i_slot_addr   (addr_v),
    .i_slot_bank   (bank_v),
    .o_slot_ok     (ok),
    .o_slot_dout   (dout),
    .o_sdram_req   (sreq),
    .o_sdram_addr  (saddr),
    .o_sdram_bank  (sbank),
    .i_sdram_ack   (ack),
    .i_data_rdy    (rdy),
    .i_data_read   (rdata),
    .o_busy        (busy),
    .o_tout_err    (tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    int          aw;
    int          rw;
    logic [31:0] data;
    bit          keep;
    int          exp;
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int s = 0; s < SLOTS; s++) begin
      addr_v[s*AW +: AW] = m_addr[s];
      bank_v[s*2 +: 2]   = m_bank[s];
    end
  endtask

  task automatic baseline();
    m_addr[0] = 22'h00777; m_bank[0] = 2'd0;
    m_addr[1] = 22'h3C0DE; m_bank[1] = 2'd3;
    m_addr[2] = 22'h12345; m_bank[2] = 2'd2;
    m_addr[3] = 22'h0A001; m_bank[3] = 2'd1;
    pack();
  endtask

  task automatic scramble();
    for (int s = 0; s < SLOTS; s++) begin
      m_addr[s] = AW'($urandom);
      m_bank[s] = 2'($urandom);
    end
    pack();
  endtask

  // Round-robin rule: first requesting slot starting at the pointer, wrapping
  function automatic int rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < SLOTS; k++) begin
      if (r[(p + k) % SLOTS]) return (p + k) % SLOTS;
    end
    return 0;
  endfunction

  // One full transaction seen from both sides; starts and ends in an IDLE cycle
  task automatic serve(input int s, input int aw, input int rw, input logic [31:0] d,
                       input bit keep, input bit dl_mid);
    logic [AW-1:0] ea;
    logic [1:0]    eb;
    ea = m_addr[s];
    eb = m_bank[s];
    tick();
    chk("grant_req", sreq, 1);
    chk("grant_busy", busy, 1);
    chk("grant_addr", saddr, ea);
    chk("grant_bank", sbank, eb);
    scramble();
    for (int k = 0; k < aw; k++) begin
      tick();
      chk("hold_req", sreq, 1);
      chk("hold_addr", {sbank, saddr}, {eb, ea});
    end
    ack = 1'b1;
    if (rw == 0) begin
      rdy   = 1'b1;
      rdata = d;
    end
    tick();
    ack = 1'b0;
    rdy = 1'b0;
    chk("ack_drop", sreq, 0);
    if (rw > 0) begin
      if (!keep) req[s] = 1'b0;
      if (dl_mid) dl = 1'b1;
      for (int k = 1; k < rw; k++) begin
        tick();
        chk("rdy_wait_ok", ok, 0);
      end
      rdy   = 1'b1;
      rdata = d;
      tick();
      rdy = 1'b0;
    end
    chk("done_ok", ok, keep ? (4'b0001 << s) : 4'b0000);
    if (keep) chk("done_dout", dout, d);
    chk("done_busy", busy, 1);
    if (keep) req[s] = 1'b0;
    tick();
    chk("idle_ok", ok, 0);
    chk("idle_busy", busy, 0);
    m_ptr = (s + 1) % SLOTS;
  endtask

  initial begin
    int s;
    int n;
    logic [AW-1:0] ea;

    vt[0] = '{4'b1111, 0, 0, 32'hA0A0_0000, 1'b1, 0};
    vt[1] = '{4'b1111, 1, 1, 32'hA1A1_1111, 1'b1, 1};
    vt[2] = '{4'b1111, 2, 0, 32'hA2A2_2222, 1'b1, 2};
    vt[3] = '{4'b1111, 0, 3, 32'hA3A3_3333, 1'b1, 3};
    vt[4] = '{4'b1111, 1, 2, 32'hA4A4_4444, 1'b1, 0};
    vt[5] = '{4'b0100, 3, 5, 32'hDEAD_BEEF, 1'b1, 2};
    vt[6] = '{4'b1010, 0, 1, 32'h0BAD_F00D, 1'b1, 3};
    vt[7] = '{4'b0010, 1, 3, 32'h5555_AAAA, 1'b0, 1};
    vt[8] = '{4'b0101, 0, 2, 32'h1234_5678, 1'b1, 2};

    baseline();
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ok", ok, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sreq", sreq, 0);
    chk("rst_saddr", saddr, 0);
    chk("rst_sbank", sbank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tout", tout, 0);
    #2 rst_n = 1'b1;
    tick();

    // Directed table: continuous four-slot rotation, single request, drop case
    for (int i = 0; i < 9; i++) begin
      baseline();
      req = vt[i].req;
      serve(vt[i].exp, vt[i].aw, vt[i].rw, vt[i].data, vt[i].keep, 1'b0);
    end

    // Downloading holds off grants; afterwards round-robin resumes
    baseline();
    req = 4'b0011;
    dl  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("dl_noreq", sreq, 0);
      chk("dl_nobusy", busy, 0);
    end
    dl = 1'b0;
    serve(rr_model(req, m_ptr), 1, 2, 32'hC0DE_0001, 1'b1, 1'b0);
    // Download raised mid-transaction does not abort it
    req = 4'b0010;
    serve(rr_model(req, m_ptr), 1, 3, 32'hC0DE_0002, 1'b1, 1'b1);
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dl2_noreq", sreq, 0);
    end
    dl = 1'b0;
    serve(rr_model(req, m_ptr), 0, 1, 32'hC0DE_0003, 1'b1, 1'b0);

    // Watchdog: no data for 255 WAIT_RDY cycles
    req = 4'b1000;
    s   = rr_model(req, m_ptr);
    ea  = m_addr[s];
    tick();
    chk("tmo_grant_addr", saddr, ea);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 254; k++) begin
      tick();
      chk("tmo_no_ok", ok, 0);
    end
    chk("tmo_busy_before", busy, 1);
    chk("tmo_err_before", tout, 0);
    tick();
    chk("tmo_busy_after", busy, 0);
    chk("tmo_err_after", tout, 1);
    chk("tmo_ok_after", ok, 0);
    m_ptr = (s + 1) % SLOTS;
    req = req | 4'b0001;
    serve(rr_model(req, m_ptr), 2, 2, 32'hFEED_0001, 1'b1, 1'b0);
    chk("tmo_sticky1", tout, 1);
    serve(rr_model(req, m_ptr), 0, 0, 32'hFEED_0002, 1'b1, 1'b0);
    chk("tmo_sticky2", tout, 1);

    // Reset during WAIT_ACK abandons the transaction and rewinds the pointer
    req = 4'b0010;
    serve(rr_model(req, m_ptr), 0, 1, 32'hBEEF_0001, 1'b1, 1'b0);
    req = 4'b1010;
    s   = rr_model(req, m_ptr);
    ea  = m_addr[s];
    tick();
    chk("prerst_grant", {sreq, saddr}, {1'b1, ea});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ok", ok, 0);
    chk("arst_dout", dout, 0);
    chk("arst_sreq", sreq, 0);
    chk("arst_saddr", saddr, 0);
    chk("arst_sbank", sbank, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tout", tout, 0);
    m_ptr = 0;
    #2 rst_n = 1'b1;
    chk("arst_release_ok", ok, 0);
    serve(rr_model(req, m_ptr), 1, 1, 32'hBEEF_0002, 1'b1, 1'b0);
    serve(rr_model(req, m_ptr), 0, 2, 32'hBEEF_0003, 1'b1, 1'b0);

    // Random traffic against the round-robin model
    for (int it = 0; it < 150; it++) begin
      logic [31:0] d;
      int aw;
      int rw;
      bit keep;
      req = req | 4'($urandom);
      if (req == 4'b0000) req = 4'($urandom_range(1, 15));
      for (int q = 0; q < SLOTS; q++) begin
        m_addr[q] = AW'($urandom);
        m_bank[q] = 2'($urandom);
      end
      pack();
      if ($urandom_range(0, 5) == 0) begin
        dl = 1'b1;
        n  = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          tick();
          chk("rnd_dl_noreq", sreq, 0);
        end
        dl = 1'b0;
      end
      aw   = $urandom_range(0, 3);
      rw   = $urandom_range(0, 4);
      keep = (rw == 0) ? 1'b1 : ($urandom_range(0, 5) != 0);
      d    = $urandom;
      serve(rr_model(req, m_ptr), aw, rw, d, keep, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
Round-robin arbiter that shares the single-port SDRAM read channel (sdram_req/sdram_addr/sdram_bank/sdram_ack/data_rdy/data_read) of the board SDRAM controller among SLOTS game ROM requesters.
Sits between game-side ROM slot caches and the jtframe board SDRAM interface. Holds one transaction in flight at a time and routes the returned 32-bit word to the granted slot.
Blocks new grants while a ROM download is active.

Parameters:
SLOTS, 4, number of requesters (2..8)
AW, 22, SDRAM word address width
TOUTW, 8, watchdog counter width; timeout fires after 2**TOUTW-1 cycles in WAIT_RDY

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
downloading  in  1  ROM download in progress; no new grants while high
slot_req  in  SLOTS  per-slot request level, held until slot_ok
slot_addr  in  SLOTS*AW  packed addresses; slot i occupies [i*AW +: AW]
slot_bank  in  SLOTS*2  packed banks; slot i occupies [i*2 +: 2]
slot_ok  out  SLOTS  one-cycle pulse to the slot that owns the returned data
slot_dout  out  32  registered read data, valid while slot_ok has any bit set
sdram_req  out  1  request to the SDRAM controller
sdram_addr  out  AW  latched address of the granted slot
sdram_bank  out  2  latched bank of the granted slot
sdram_ack  in  1  controller accepted the request
data_rdy  in  1  data_read is valid
data_read  in  32  SDRAM read data
busy  out  1  high outside IDLE
tout_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (asynchronous, rst_n low) forces every output to 0: slot_ok, slot_dout, sdram_req, sdram_addr, sdram_bank, busy, tout_err. It also sets state=IDLE, rr_ptr=0, gnt=0 and the watchdog counter to 0. A reset in the middle of a transaction abandons it; no slot_ok is issued afterwards.
- Round-robin pick: search starts at rr_ptr and wraps modulo SLOTS. The first slot i with slot_req[i]=1 wins.
- State IDLE:
  - If downloading=0 and any slot_req bit is set, latch gnt=i, sdram_addr=slot_addr[i], sdram_bank=slot_bank[i].
  - Set sdram_req=1 and go to WAIT_ACK; busy=1 from the next cycle.
  - A grant is registered one cycle after slot_req rises.
- State WAIT_ACK:
  - Hold sdram_req, sdram_addr and sdram_bank stable.
  - On sdram_ack=1, set sdram_req=0, clear the watchdog and go to WAIT_RDY.
  - If sdram_ack and data_rdy arrive in the same cycle, treat it as ack followed by rdy: go straight to DONE.
- State WAIT_RDY:
  - On data_rdy=1, register slot_dout=data_read and go to DONE.
  - Otherwise increment the watchdog. When it reaches all-ones, set tout_err=1, go to IDLE without issuing slot_ok, and set rr_ptr=gnt+1.
- State DONE (one cycle):
  - slot_ok[gnt]=1 only if slot_req[gnt] is still 1. If the slot withdrew its request, the data is dropped silently.
  - rr_ptr = (gnt+1) mod SLOTS, then go to IDLE.
  - Total latency from grant to slot_ok = ack wait + rdy wait + 1 cycle.
- Back-to-back requests: IDLE can grant the next slot in the cycle after DONE. The peak rate is therefore one grant per (ack + rdy + 2) cycles.
- Fairness: after slot i is served, every other slot that has a request pending is served before i again.
- Downloading:
  - Assertion mid-transaction does not abort it; the in-flight transaction completes normally.
  - The block stays in IDLE while downloading=1.
- Changes to slot_addr or slot_bank after a grant are ignored, because the values are latched.
- tout_err is cleared only by reset.
- State encoding is binary: IDLE=0, WAIT_ACK=1, WAIT_RDY=2, DONE=3.

Decomposition:
- Package jtframe_sdram_arb_pkg holds:
  - the state enum (IDLE, WAIT_ACK, WAIT_RDY, DONE);
  - the localparam for the data width (32).
- Sub-module jtframe_rr_pick: purely combinational round-robin priority picker.
  - Inputs: req[SLOTS], ptr[$clog2(SLOTS)].
  - Outputs: valid, idx.
  - Instantiated once; unit-tested on its own.

Test Plan:
- Single request: slot_req=4'b0100, slot_addr[2]=22'h12345, bank 2, ack after 3 cycles, rdy 5 cycles later with data 32'hDEADBEEF.
  -> sdram_addr=22'h12345, sdram_bank=2; slot_ok=4'b0100 for exactly one cycle; slot_dout=32'hDEADBEEF.
- All four slots request continuously with rr_ptr=0.
  -> grant order 0,1,2,3,0; each slot_ok pulse goes to the matching bit; no slot is served twice before the others.
- downloading=1 while slot_req=4'b0011.
  -> sdram_req stays 0 and busy=0. After downloading falls, slot 0 is granted first.
  - Also: assert downloading during WAIT_RDY -> that transaction still completes with slot_ok.
- Slot 1 drops slot_req during WAIT_RDY.
  -> no slot_ok pulse; rr_ptr advances to 2; the next grant goes to slot 2 if it is requesting.
- No data_rdy for 255 cycles after ack (TOUTW=8).
  -> tout_err=1; state returns to IDLE; no slot_ok. A following request is still served normally and tout_err stays 1.
- rst_n low during WAIT_ACK, then rst_n high.
  -> all outputs are 0 immediately (asynchronously); no stale slot_ok; the first grant after reset goes to the lowest requesting slot.
